// File: rtl/lbmem_pkg.sv
// Shared types and parameter checks for the line-buffer memory.
package lbmem_pkg;

    // Buffer operating mode: accumulate a window, stream it, or empty it.
    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } lb_state_t;

    // Default geometry used when a parent does not override the parameters.
    localparam int LB_DEF_WIDTH      = 8;
    localparam int LB_DEF_DEPTH      = 64;
    localparam int LB_DEF_LINE       = 8;
    localparam int LB_DEF_AUTO_DRAIN = 1;

    // True when depth is a power of two (>= 2) and 1 <= line <= depth.
    function automatic bit lb_params_ok(input int depth, input int line);
        bit pow2;
        pow2 = (depth >= 2) && ((depth & (depth - 1)) == 0);
        return pow2 && (line >= 1) && (line <= depth);
    endfunction

endpackage

// File: rtl/lbmem_ram.sv
// Storage array for the line buffer: one synchronous write port and one
// asynchronous read port, so the head word is visible without a read cycle.
module lbmem_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // First-word fall-through read of the current head entry.
    assign rdata = mem[raddr];

endmodule

// File: rtl/lbmem_stream.sv
// Line-buffer memory: circular store that fills to LINE words, then releases
// each word LINE accepted writes after it arrived; drains leftovers when the
// producer stops (AUTO_DRAIN) or on a flush pulse.
//
// Handshakes: a write transfers on a cycle where wen && wready; a read
// transfers on a cycle where rvalid && rready. wready and rvalid depend only
// on registered state, never on wen/rready, so neither side can create a
// combinational loop through this block.
module lbmem_stream
    import lbmem_pkg::*;
#(
    parameter int WIDTH      = LB_DEF_WIDTH,
    parameter int DEPTH      = LB_DEF_DEPTH,
    parameter int LINE       = LB_DEF_LINE,
    parameter int AUTO_DRAIN = LB_DEF_AUTO_DRAIN
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     wen,
    output logic                     wready,
    output logic [WIDTH-1:0]         rdata,
    output logic                     rvalid,
    input  logic                     rready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LINE_C  = CW'(LINE);
    localparam logic [CW-1:0] ZERO_C  = '0;
    localparam bit            AD      = (AUTO_DRAIN != 0);

    if (!lb_params_ok(DEPTH, LINE)) begin : g_bad_params
        $error("lbmem_stream: DEPTH must be a power of two >= 2 and 1 <= LINE <= DEPTH");
    end

    // Mode register, kept as a named signal so checkers can observe it.
    lb_state_t state;

    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic          wr_fire;
    logic          rd_fire;
    logic [CW-1:0] count_next;
    logic          drain_blocks_wr;

    // Without auto-drain a flush owns the buffer until it is empty, so
    // writes are held off for the whole drain.
    assign drain_blocks_wr = (state == DRAIN) && !AD;

    assign wready = (count != DEPTH_C) && !drain_blocks_wr;

    assign rvalid = ((state == STREAM) && (count >= LINE_C)) ||
                    ((state == DRAIN)  && (count != ZERO_C));

    assign wr_fire = wen && wready;
    assign rd_fire = rvalid && rready;

    // Occupancy after this edge: used both for the counter and for FSM
    // decisions so that mode changes see the post-transfer fill level.
    always_comb begin
        count_next = count;
        count_next = count + CW'(wr_fire) - CW'(rd_fire);
    end

    lbmem_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .CLK   (CLK),
        .we    (wr_fire),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Circular pointers and occupancy; pointer width gives the modulo wrap.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            waddr <= '0;
            raddr <= '0;
            count <= '0;
        end else begin
            if (wr_fire) begin
                waddr <= waddr + AW'(1);
            end
            if (rd_fire) begin
                raddr <= raddr + AW'(1);
            end
            count <= count_next;
        end
    end

    // Sticky record that the producer pushed while the buffer refused it.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            overflow <= 1'b0;
        end else if (wen && !wready) begin
            overflow <= 1'b1;
        end
    end

    // Mode sequencing; flush wins over every other condition.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= FILL;
        end else begin
            case (state)
                FILL: begin
                    if (flush && (count_next != ZERO_C)) begin
                        state <= DRAIN;
                    end else if (count_next >= LINE_C) begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (flush) begin
                        state <= DRAIN;
                    end else if (AD && !wen) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count_next == ZERO_C) begin
                        state <= FILL;
                    end else if (AD && wr_fire && (count_next >= LINE_C)) begin
                        state <= STREAM;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
